operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameters: none; fixed 32 registers x 32 bits, 5-bit register index.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 regWrite  input  1  write-back enable from write-back stage.
REQ-005 writeReg  input  5  write-back destination index.
REQ-006 writeData  input  32  write-back data (selected memory or ALU result).
REQ-007 readReg1  input  5  source operand 1 index.
REQ-008 readReg2  input  5  source operand 2 index.
REQ-009 issueValid  input  1  decode stage presents an instruction this cycle.
REQ-010 issueWrites  input  1  presented instruction will write a register.
REQ-011 issueDest  input  5  presented instruction's destination index.
REQ-012 readData1  output  32  operand 1 value.
REQ-013 readData2  output  32  operand 2 value.
REQ-014 stall  output  1  presented instruction must hold; not accepted this cycle.
REQ-015 pendingCount  output  6  number of registers with a write outstanding (0..31).

Function
REQ-016 Storage: 32 x 32-bit registers; register 0 reads 0 always; writes to index 0 are ignored.
REQ-017 Write: on rising clk with regWrite=1 and writeReg!=0, register[writeReg] <= writeData.
REQ-018 Read: readDataN combinational; register 0 -> 0; else if regWrite=1 and writeReg==readRegN -> writeData (same-cycle bypass); else register[readRegN].
REQ-019 Scoreboard: one busy bit per register; busy[0] constant 0.
REQ-020 Accept: instruction accepted when issueValid=1 and stall=0.
REQ-021 Set: on accept with issueWrites=1 and issueDest!=0, busy[issueDest] <= 1 at next edge.
REQ-022 Clear: on rising clk with regWrite=1 and writeReg!=0, busy[writeReg] <= 0.
REQ-023 Simultaneous set and clear on same index in one cycle: set wins (busy stays 1).
REQ-024 Hazard on source N: readRegN!=0, busy[readRegN]=1, and not (regWrite=1 and writeReg==readRegN).
REQ-025 WAW hazard: issueWrites=1, issueDest!=0, busy[issueDest]=1, and not (regWrite=1 and writeReg==issueDest).
REQ-026 stall = issueValid AND (hazard on source 1 OR hazard on source 2 OR WAW hazard); combinational; stall=0 when issueValid=0.
REQ-027 Sources checked regardless of whether instruction uses them; unused fields must be driven 0 by decode.
REQ-028 pendingCount registered; equals popcount of busy after each edge; incremented/decremented per REQ-021/022/023 (set+clear on different indices -> unchanged; same index -> unchanged, busy stays 1).
REQ-029 Write-back to a non-busy register still writes data; busy unchanged, pendingCount unchanged (no underflow).
REQ-030 Latency: write visible to readData combinationally in the write cycle (bypass), from storage thereafter; stall released in the write-back cycle itself.

Reset
REQ-031 rst=1 asynchronously clears all 32 registers to 0, all busy bits to 0, pendingCount to 0.
REQ-032 During reset readData1=readData2=0 and stall=0; write and issue inputs ignored while rst=1.
REQ-033 Reset asserted mid-operation discards outstanding busy bits; first edge after deassertion behaves as from power-up.

Verification
REQ-034 Reset, then regWrite=1 writeReg=5 writeData=0xDEADBEEF; same cycle readReg1=5 -> readData1=0xDEADBEEF (bypass); next cycle still 0xDEADBEEF from storage.
REQ-035 Write writeReg=0 writeData=0x12345678, readReg1=0 -> readData1=0, pendingCount=0, no busy set.
REQ-036 Issue issueWrites=1 issueDest=3 accepted; next cycle issueValid=1 readReg2=3 -> stall=1, pendingCount=1; cycle with regWrite=1 writeReg=3 writeData=0x55 -> stall=0, readData2=0x55; after edge pendingCount=0.
REQ-037 busy[7]=1; same cycle regWrite=1 writeReg=7 and accepted issue with issueDest=7 -> after edge busy[7]=1, pendingCount=1.
REQ-038 busy[9]=1; issue issueDest=9 without write-back -> stall=1 (WAW), pendingCount unchanged; issueValid=0 -> stall=0.
REQ-039 Issue dests 1,2,4 accepted (pendingCount=3), assert rst asynchronously between edges -> pendingCount=0, readData of register 1=0, readReg1=1 no stall after release.

Source files
------------

// File: rtl/operand_fetch_if.sv
// Operand-fetch bus: write-back port, two source read ports, and the issue
// handshake from decode.
//   master (decode/write-back side): drives write-back, read indices, issue fields
//   slave  (operand_fetch):          returns operand data, stall and pending count
interface operand_fetch_if;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic        issueValid;
    logic        issueWrites;
    logic [4:0]  issueDest;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic        stall;
    logic [5:0]  pendingCount;

    modport master (
        output regWrite, writeReg, writeData, readReg1, readReg2,
               issueValid, issueWrites, issueDest,
        input  readData1, readData2, stall, pendingCount
    );

    modport slave (
        input  regWrite, writeReg, writeData, readReg1, readReg2,
               issueValid, issueWrites, issueDest,
        output readData1, readData2, stall, pendingCount
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: 32x32 register file with write-back bypass plus a busy-bit
// scoreboard that stalls issue on RAW/WAW hazards.
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (clears registers, busy bits, count)
//   bus  - operand_fetch_if.slave: write-back, read ports, issue handshake,
//          readData1/2, stall, pendingCount
module operand_fetch (
    input  logic            clk,
    input  logic            rst,
    operand_fetch_if.slave  bus
);
    logic [31:0] regs_q [32];
    logic [31:0] busy_q, busy_d;
    logic [5:0]  pending_q, pending_d;

    logic wr_en, issue_en, set_en, accept;
    logic haz1, haz2, haz_waw, stall_c;
    logic inc, dec;

    // Inputs are ignored while reset is held.
    assign wr_en    = !rst && bus.regWrite && (bus.writeReg != 5'd0);
    assign issue_en = !rst && bus.issueValid;

    // Read ports with same-cycle write-back bypass.
    always_comb begin
        bus.readData1 = '0;
        if (!rst && bus.readReg1 != 5'd0) begin
            if (wr_en && bus.writeReg == bus.readReg1) bus.readData1 = bus.writeData;
            else                                       bus.readData1 = regs_q[bus.readReg1];
        end
    end

    always_comb begin
        bus.readData2 = '0;
        if (!rst && bus.readReg2 != 5'd0) begin
            if (wr_en && bus.writeReg == bus.readReg2) bus.readData2 = bus.writeData;
            else                                       bus.readData2 = regs_q[bus.readReg2];
        end
    end

    // A busy register being written back this cycle no longer blocks issue.
    assign haz1 = (bus.readReg1 != 5'd0) && busy_q[bus.readReg1] &&
                  !(wr_en && bus.writeReg == bus.readReg1);
    assign haz2 = (bus.readReg2 != 5'd0) && busy_q[bus.readReg2] &&
                  !(wr_en && bus.writeReg == bus.readReg2);
    assign haz_waw = bus.issueWrites && (bus.issueDest != 5'd0) && busy_q[bus.issueDest] &&
                     !(wr_en && bus.writeReg == bus.issueDest);

    assign stall_c   = issue_en && (haz1 || haz2 || haz_waw);
    assign bus.stall = stall_c;
    assign accept    = issue_en && !stall_c;
    assign set_en    = accept && bus.issueWrites && (bus.issueDest != 5'd0);

    // Set is applied after clear so a same-index set/clear leaves the bit busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_en)  busy_d[bus.writeReg]  = 1'b0;
        if (set_en) busy_d[bus.issueDest] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Count only real bit transitions: set on an already-busy bit or clear of an
    // idle bit leaves the count alone.
    assign inc = set_en && !busy_q[bus.issueDest];
    assign dec = wr_en && busy_q[bus.writeReg] &&
                 !(set_en && bus.issueDest == bus.writeReg);
    assign pending_d = pending_q + {5'd0, inc} - {5'd0, dec};

    assign bus.pendingCount = pending_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
            busy_q    <= '0;
            pending_q <= '0;
        end else begin
            if (wr_en) regs_q[bus.writeReg] <= bus.writeData;
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    operand_fetch_if bus ();

    operand_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural register contents and outstanding writes.
    logic [31:0] m_regs [32];
    bit   [31:0] m_busy;

    function automatic int m_pending();
        int n = 0;
        for (int i = 0; i < 32; i++) if (m_busy[i]) n++;
        return n;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] idx);
        if (rst || idx == 5'd0) return 32'd0;
        if (bus.regWrite && bus.writeReg == idx) return bus.writeData;
        return m_regs[idx];
    endfunction

    function automatic bit blocks(input logic [4:0] idx);
        return idx != 5'd0 && m_busy[idx] && !(bus.regWrite && bus.writeReg == idx);
    endfunction

    function automatic bit exp_stall();
        if (rst || !bus.issueValid) return 1'b0;
        return blocks(bus.readReg1) || blocks(bus.readReg2) ||
               (bus.issueWrites && blocks(bus.issueDest));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = '0;
    endtask

    task automatic idle();
        bus.regWrite = 0; bus.writeReg = 0; bus.writeData = 0;
        bus.readReg1 = 0; bus.readReg2 = 0;
        bus.issueValid = 0; bus.issueWrites = 0; bus.issueDest = 0;
    endtask

    // Advance one rising edge, applying the architectural effect of the
    // current inputs to the model.
    task automatic tick();
        bit acc;
        acc = bus.issueValid && !exp_stall();
        if (!rst) begin
            if (bus.regWrite && bus.writeReg != 0) begin
                m_regs[bus.writeReg] = bus.writeData;
                m_busy[bus.writeReg] = 1'b0;
            end
            if (acc && bus.issueWrites && bus.issueDest != 0) m_busy[bus.issueDest] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic issue_dest(input logic [4:0] d);
        idle();
        bus.issueValid = 1; bus.issueWrites = 1; bus.issueDest = d;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        bus.regWrite = 1; bus.writeReg = 5; bus.writeData = 32'hCAFE0001;
        bus.readReg1 = 5; bus.readReg2 = 3;
        bus.issueValid = 1; bus.issueWrites = 1; bus.issueDest = 3;
        #1;
        checks++;
        if (bus.readData1 !== 32'd0) begin
            errors++; $display("FAIL reset_rd1 got %h want %h", bus.readData1, 32'd0);
        end
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall got %b want 0", bus.stall);
        end
        checks++;
        if (bus.pendingCount !== 6'd0) begin
            errors++; $display("FAIL reset_pending got %0d want 0", bus.pendingCount);
        end
        tick();
        rst = 1'b0;
        idle();
        bus.readReg1 = 5;
        #1;
        checks++;
        if (bus.readData1 !== 32'd0) begin
            errors++; $display("FAIL reset_ignored_write got %h want 0", bus.readData1);
        end
        checks++;
        if (bus.pendingCount !== 6'd0) begin
            errors++; $display("FAIL reset_ignored_issue got %0d want 0", bus.pendingCount);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        bus.regWrite = 1; bus.writeReg = 5; bus.writeData = 32'hDEADBEEF; bus.readReg1 = 5;
        #1;
        checks++;
        if (bus.readData1 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL bypass_rd1 got %h want deadbeef", bus.readData1);
        end
        tick();
        bus.regWrite = 0;
        #1;
        checks++;
        if (bus.readData1 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL stored_rd1 got %h want deadbeef", bus.readData1);
        end
    endtask

    task automatic test_reg0();
        idle();
        bus.regWrite = 1; bus.writeReg = 0; bus.writeData = 32'h12345678; bus.readReg1 = 0;
        #1;
        checks++;
        if (bus.readData1 !== 32'd0) begin
            errors++; $display("FAIL reg0_bypass got %h want 0", bus.readData1);
        end
        tick();
        bus.regWrite = 0;
        #1;
        checks++;
        if (bus.readData1 !== 32'd0 || bus.pendingCount !== 6'd0) begin
            errors++;
            $display("FAIL reg0_store got %h/%0d want 0/0", bus.readData1, bus.pendingCount);
        end
    endtask

    task automatic test_raw();
        do_reset();
        bus.issueValid = 1; bus.issueWrites = 1; bus.issueDest = 3;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL raw_first_issue got %b want 0", bus.stall);
        end
        tick();
        idle();
        bus.issueValid = 1; bus.readReg2 = 3;
        #1;
        checks++;
        if (bus.stall !== 1'b1 || bus.pendingCount !== 6'd1) begin
            errors++;
            $display("FAIL raw_stall got %b/%0d want 1/1", bus.stall, bus.pendingCount);
        end
        tick();
        bus.regWrite = 1; bus.writeReg = 3; bus.writeData = 32'h55;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.readData2 !== 32'h55) begin
            errors++;
            $display("FAIL raw_release got %b/%h want 0/00000055", bus.stall, bus.readData2);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.pendingCount !== 6'd0) begin
            errors++; $display("FAIL raw_pending got %0d want 0", bus.pendingCount);
        end
    endtask

    task automatic test_set_clear();
        do_reset();
        issue_dest(7);
        bus.regWrite = 1; bus.writeReg = 7; bus.writeData = 32'h77;
        bus.issueValid = 1; bus.issueWrites = 1; bus.issueDest = 7;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL setclr_stall got %b want 0", bus.stall);
        end
        tick();
        idle();
        bus.issueValid = 1; bus.readReg1 = 7;
        #1;
        checks++;
        if (bus.pendingCount !== 6'd1 || bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL setclr_busy got %0d/%b want 1/1", bus.pendingCount, bus.stall);
        end
        idle();
    endtask

    task automatic test_waw();
        do_reset();
        issue_dest(9);
        bus.issueValid = 1; bus.issueWrites = 1; bus.issueDest = 9;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++; $display("FAIL waw_stall got %b want 1", bus.stall);
        end
        tick();
        checks++;
        if (bus.pendingCount !== 6'd1) begin
            errors++; $display("FAIL waw_pending got %0d want 1", bus.pendingCount);
        end
        bus.issueValid = 0;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL waw_novalid got %b want 0", bus.stall);
        end
        idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.regWrite = 1; bus.writeReg = 1; bus.writeData = 32'hAA;
        tick();
        issue_dest(1);
        issue_dest(2);
        issue_dest(4);
        checks++;
        if (bus.pendingCount !== 6'd3) begin
            errors++; $display("FAIL async_pre got %0d want 3", bus.pendingCount);
        end
        #3;
        rst = 1'b1;
        m_reset();
        bus.readReg1 = 1;
        #1;
        checks++;
        if (bus.pendingCount !== 6'd0 || bus.readData1 !== 32'd0) begin
            errors++;
            $display("FAIL async_clear got %0d/%h want 0/0", bus.pendingCount, bus.readData1);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.issueValid = 1; bus.readReg1 = 1;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.readData1 !== 32'd0) begin
            errors++;
            $display("FAIL async_release got %b/%h want 0/0", bus.stall, bus.readData1);
        end
        tick();
        idle();
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        bit          es;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bus.regWrite    = 1'($urandom_range(0, 1));
            bus.writeReg    = 5'($urandom_range(0, 7));
            bus.writeData   = $urandom;
            bus.readReg1    = 5'($urandom_range(0, 7));
            bus.readReg2    = 5'($urandom_range(0, 7));
            bus.issueValid  = 1'($urandom_range(0, 1));
            bus.issueWrites = 1'($urandom_range(0, 1));
            bus.issueDest   = 5'($urandom_range(0, 7));
            #1;
            e1 = exp_rd(bus.readReg1);
            e2 = exp_rd(bus.readReg2);
            es = exp_stall();
            checks++;
            if (bus.readData1 !== e1 || bus.readData2 !== e2 || bus.stall !== es) begin
                errors++;
                $display("FAIL rand_comb cyc %0d got %h %h %b want %h %h %b",
                         n, bus.readData1, bus.readData2, bus.stall, e1, e2, es);
            end
            tick();
            checks++;
            if (bus.pendingCount !== 6'(m_pending())) begin
                errors++;
                $display("FAIL rand_pending cyc %0d got %0d want %0d",
                         n, bus.pendingCount, m_pending());
            end
        end
        idle();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        m_reset();
        idle();
        test_reset();
        test_bypass();
        test_reg0();
        test_raw();
        test_set_clear();
        test_waw();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
